// File: rtl/ctrl_defs.sv
// rtl/ctrl_defs.sv - shared constants and encodings for the writeback controller
// Purpose: FSM state encoding, MIPS opcode/funct constants, RegDst and
//          write-data source encodings used by ctrl_writeback and decod_wb.
// Ports:   none (package).
package ctrl_defs;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DECODE = 2'd1,
        ST_MEM    = 2'd2,
        ST_WB     = 2'd3
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_ADDIU = 6'h09;
    localparam logic [5:0] OP_SLTI  = 6'h0A;
    localparam logic [5:0] OP_LUI   = 6'h0F;
    localparam logic [5:0] OP_LW    = 6'h23;

    localparam logic [5:0] FN_JR    = 6'h08;

    // RegDst mux selects; 011..111 are reserved and never produced
    localparam logic [2:0] DST_RT = 3'b000;
    localparam logic [2:0] DST_RD = 3'b001;
    localparam logic [2:0] DST_RA = 3'b010;

    // register write-data source
    localparam logic [1:0] SRC_ALU = 2'b00;
    localparam logic [1:0] SRC_MEM = 2'b01;
    localparam logic [1:0] SRC_PC4 = 2'b10;
    localparam logic [1:0] SRC_LUI = 2'b11;

endpackage

// File: rtl/decod_wb.sv
// rtl/decod_wb.sv - combinational writeback decode table
// Purpose: maps a latched opcode/funct pair to the RegDst select, write-data
//          source, register-write enable and load flag.
// Ports:   opcode, funct (in, 6 each); reg_dst (out, 3); mem_src (out, 2);
//          wr (out, 1); is_load (out, 1).
import ctrl_defs::*;

module decod_wb (
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    output logic [2:0] reg_dst,
    output logic [1:0] mem_src,
    output logic       wr,
    output logic       is_load
);

    always_comb begin
        reg_dst = DST_RT;
        mem_src = SRC_ALU;
        wr      = 1'b0;
        is_load = 1'b0;
        case (opcode)
            OP_RTYPE: begin
                reg_dst = DST_RD;
                wr      = (funct != FN_JR);
            end
            OP_LW: begin
                mem_src = SRC_MEM;
                wr      = 1'b1;
                is_load = 1'b1;
            end
            OP_ADDI, OP_ADDIU, OP_SLTI: begin
                wr      = 1'b1;
            end
            OP_LUI: begin
                mem_src = SRC_LUI;
                wr      = 1'b1;
            end
            OP_JAL: begin
                reg_dst = DST_RA;
                mem_src = SRC_PC4;
                wr      = 1'b1;
            end
            default: begin
                wr      = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/ctrl_writeback.sv
// rtl/ctrl_writeback.sv - IDLE/DECODE/MEM/WB writeback control FSM
// Purpose: accepts one instruction at a time, decodes its writeback controls,
//          waits for load data, then pulses done/reg_write for one cycle.
// Ports:   clk, reset (sync, active-high), instr_valid, opcode[5:0],
//          funct[5:0], mem_ready (in); reg_dst_sel[2:0], mem_to_reg_sel[1:0],
//          reg_write, mem_read, busy, done, err (out).
// Config:  CTRL_WB_TIMEOUT_EN enables the MEM-wait timeout counter and err
//          pulse; TIMEOUT_CYCLES sets the MEM cycle limit.
import ctrl_defs::*;

module ctrl_writeback #(
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       instr_valid,
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    input  logic       mem_ready,
    output logic [2:0] reg_dst_sel,
    output logic [1:0] mem_to_reg_sel,
    output logic       reg_write,
    output logic       mem_read,
    output logic       busy,
    output logic       done,
    output logic       err
);

    state_t     state;
    state_t     state_n;
    logic [5:0] op_q;
    logic [5:0] fn_q;
    logic [2:0] dec_dst;
    logic [1:0] dec_src;
    logic       dec_wr;
    logic       dec_load;
    logic       timeout;

    decod_wb u_decod (
        .opcode  (op_q),
        .funct   (fn_q),
        .reg_dst (dec_dst),
        .mem_src (dec_src),
        .wr      (dec_wr),
        .is_load (dec_load)
    );

`ifdef CTRL_WB_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

    logic [CW-1:0] cnt;
    logic          err_q;

    // cnt holds the number of MEM cycles already spent, so the last allowed
    // MEM cycle is the one where cnt reaches TIMEOUT_CYCLES-1
    assign timeout = (state == ST_MEM) && !mem_ready &&
                     (cnt == CW'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt   <= '0;
            err_q <= 1'b0;
        end else begin
            cnt   <= (state == ST_MEM) ? cnt + 1'b1 : '0;
            err_q <= timeout;
        end
    end

    assign err = err_q;
`else
    wire unused_timeout_cfg = (TIMEOUT_CYCLES == 0);

    assign timeout = 1'b0;
    assign err     = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ST_IDLE;
            op_q  <= '0;
            fn_q  <= '0;
        end else begin
            state <= state_n;
            if (state == ST_IDLE && instr_valid) begin
                op_q <= opcode;
                fn_q <= funct;
            end
        end
    end

    always_comb begin
        state_n        = state;
        reg_dst_sel    = 3'b000;
        mem_to_reg_sel = 2'b00;
        reg_write      = 1'b0;
        mem_read       = 1'b0;
        busy           = 1'b0;
        done           = 1'b0;
        case (state)
            ST_IDLE: begin
                if (instr_valid) state_n = ST_DECODE;
            end
            ST_DECODE: begin
                busy           = 1'b1;
                reg_dst_sel    = dec_dst;
                mem_to_reg_sel = dec_src;
                state_n        = dec_load ? ST_MEM : ST_WB;
            end
            ST_MEM: begin
                busy           = 1'b1;
                mem_read       = 1'b1;
                reg_dst_sel    = dec_dst;
                mem_to_reg_sel = dec_src;
                // mem_ready wins over an expiring timeout in the same cycle
                if (mem_ready)    state_n = ST_WB;
                else if (timeout) state_n = ST_IDLE;
            end
            ST_WB: begin
                busy           = 1'b1;
                done           = 1'b1;
                reg_write      = dec_wr;
                reg_dst_sel    = dec_dst;
                mem_to_reg_sel = dec_src;
                state_n        = ST_IDLE;
            end
            default: state_n = ST_IDLE;
        endcase
    end

endmodule

// File: tb/tb_ctrl_writeback.sv
// tb/tb_ctrl_writeback.sv - self-checking bench for ctrl_writeback
module tb_ctrl_writeback;

    localparam int TO = 4;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       instr_valid = 1'b0;
    logic [5:0] opcode = '0;
    logic [5:0] funct = '0;
    logic       mem_ready = 1'b0;
    logic [2:0] reg_dst_sel;
    logic [1:0] mem_to_reg_sel;
    logic       reg_write, mem_read, busy, done, err;

    int total = 0;
    int bad = 0;
    int cyc = 0;
    bit started = 0;

    ctrl_writeback #(.TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .reset(reset), .instr_valid(instr_valid),
        .opcode(opcode), .funct(funct), .mem_ready(mem_ready),
        .reg_dst_sel(reg_dst_sel), .mem_to_reg_sel(mem_to_reg_sel),
        .reg_write(reg_write), .mem_read(mem_read), .busy(busy),
        .done(done), .err(err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // decode rules as a table: {write, reg_dst_sel, mem_to_reg_sel}
    function automatic logic [5:0] ref_decode(input logic [5:0] op, input logic [5:0] fn);
        if (op == 6'h00)                          return (fn == 6'h08) ? 6'b0_001_00 : 6'b1_001_00;
        if (op == 6'h23)                          return 6'b1_000_01;
        if (op == 6'h08 || op == 6'h09 || op == 6'h0A) return 6'b1_000_00;
        if (op == 6'h0F)                          return 6'b1_000_11;
        if (op == 6'h03)                          return 6'b1_010_10;
        return 6'b0_000_00;
    endfunction

    // model: an accepted instruction is tracked by its age in cycles since
    // acceptance; wb_age is the age at which done is due (0 = still waiting)
    bit         m_act = 0;
    bit         m_load = 0;
    bit         m_err = 0;
    int         m_age = 0;
    int         m_wb = 0;
    logic [5:0] m_op = '0, m_fn = '0;

    always @(posedge clk) begin
        bit e_n;
        logic [5:0] d;
        bit e_done;
        cyc++;
        e_n = 0;
        if (reset) begin
            started = 1;
            m_act = 0;
        end else if (m_act) begin
            if (m_age == m_wb) begin
                m_act = 0;
            end else begin
                if (m_load && m_wb == 0 && m_age >= 2) begin
                    if (mem_ready) m_wb = m_age + 1;
`ifdef CTRL_WB_TIMEOUT_EN
                    else if (m_age - 1 == TO) begin
                        m_act = 0;
                        e_n = 1;
                    end
`endif
                end
                m_age++;
            end
        end else if (instr_valid) begin
            m_act = 1; m_age = 1; m_op = opcode; m_fn = funct;
            m_load = (opcode == 6'h23);
            m_wb = m_load ? 0 : 2;
        end
        m_err = e_n;
        #1;
        if (started) begin
            d = ref_decode(m_op, m_fn);
            e_done = m_act && (m_age == m_wb);
            chk("mon_busy", busy, m_act);
            chk("mon_done", done, e_done);
            chk("mon_mem_read", mem_read, m_act && m_load && m_age >= 2 && m_wb == 0);
            chk("mon_reg_write", reg_write, e_done && d[5]);
            chk("mon_reg_dst_sel", reg_dst_sel, m_act ? d[4:2] : 3'b000);
            chk("mon_mem_to_reg_sel", mem_to_reg_sel, m_act ? d[1:0] : 2'b00);
            chk("mon_err", err, m_err);
            total++;
            if (reg_dst_sel > 3'b010) begin
                bad++;
                $display("FAIL reserved_sel: got %0d want <=2", reg_dst_sel);
            end
        end
    end

    // issues one instruction; mem_at is the cycle offset (from the accept
    // cycle) at which mem_ready is pulsed, 0 for none
    task automatic run_instr(input logic [5:0] op, input logic [5:0] fn, input int mem_at,
                             output int lat, output logic [2:0] sel, output logic [1:0] src,
                             output logic rw, output int mrcnt);
        int acc;
        @(negedge clk);
        instr_valid = 1; opcode = op; funct = fn;
        acc = cyc; lat = -1; mrcnt = 0; sel = 'x; src = 'x; rw = 'x;
        for (int k = 0; k < 60; k++) begin
            @(posedge clk); #2;
            if (mem_read) mrcnt++;
            if (done) begin
                lat = cyc - acc; sel = reg_dst_sel; src = mem_to_reg_sel; rw = reg_write;
                break;
            end
            @(negedge clk);
            instr_valid = 0;
            mem_ready = (mem_at != 0) && (cyc - acc == mem_at);
        end
        @(negedge clk);
        instr_valid = 0; mem_ready = 0;
        if (lat < 0) begin
            total++; bad++;
            $display("FAIL done_timeout: got no done want done within 60 cycles");
        end
    endtask

    typedef struct { logic [5:0] op; logic [5:0] fn; int mem_at; int lat;
                     logic [2:0] sel; logic [1:0] src; logic rw; int mr; } vec_t;

    initial begin
        vec_t vecs[$];
        int lat, mr, acc, first_done, second_done, err_at;
        logic [2:0] sel; logic [1:0] src; logic rw;
        bit saw_done;

        repeat (3) @(posedge clk);
        #2;
        chk("reset_busy", busy, 0);
        chk("reset_outs", {reg_dst_sel, mem_to_reg_sel, reg_write, mem_read, done, err}, 0);
        @(negedge clk); reset = 0;

        vecs.push_back('{6'h00, 6'h20, 0, 2, 3'b001, 2'b00, 1, 0}); // add
        vecs.push_back('{6'h23, 6'h00, 4, 5, 3'b000, 2'b01, 1, 3}); // lw, 3 MEM cycles
        vecs.push_back('{6'h03, 6'h00, 0, 2, 3'b010, 2'b10, 1, 0}); // jal
        vecs.push_back('{6'h00, 6'h08, 0, 2, 3'b001, 2'b00, 0, 0}); // jr
        vecs.push_back('{6'h0F, 6'h15, 0, 2, 3'b000, 2'b11, 1, 0}); // lui
        vecs.push_back('{6'h08, 6'h3F, 0, 2, 3'b000, 2'b00, 1, 0}); // addi
        vecs.push_back('{6'h04, 6'h20, 0, 2, 3'b000, 2'b00, 0, 0}); // beq: no write
        vecs.push_back('{6'h23, 6'h00, 2, 3, 3'b000, 2'b01, 1, 1}); // lw, ready at first MEM
        foreach (vecs[i]) begin
            run_instr(vecs[i].op, vecs[i].fn, vecs[i].mem_at, lat, sel, src, rw, mr);
            chk($sformatf("v%0d_latency", i), lat, vecs[i].lat);
            chk($sformatf("v%0d_sel", i), sel, vecs[i].sel);
            chk($sformatf("v%0d_src", i), src, vecs[i].src);
            chk($sformatf("v%0d_reg_write", i), rw, vecs[i].rw);
            chk($sformatf("v%0d_mem_read_cycles", i), mr, vecs[i].mr);
        end

        // instr_valid held high: second add accepted only in the IDLE after done
        @(negedge clk);
        instr_valid = 1; opcode = 6'h00; funct = 6'h20;
        acc = cyc; first_done = -1; second_done = -1;
        for (int k = 0; k < 20 && second_done < 0; k++) begin
            @(posedge clk); #2;
            if (done) begin
                if (first_done < 0) first_done = cyc - acc;
                else second_done = cyc - acc;
            end
        end
        @(negedge clk); instr_valid = 0;
        chk("hold_first_done", first_done, 2);
        chk("hold_second_done", second_done, 5);

        // reset taken during MEM
        repeat (2) @(negedge clk);
        instr_valid = 1; opcode = 6'h23; funct = 6'h00;
        @(negedge clk); instr_valid = 0;
        @(negedge clk);
        @(negedge clk); reset = 1;
        @(posedge clk); #2;
        chk("rst_mem_busy", busy, 0);
        chk("rst_mem_outs", {reg_dst_sel, mem_to_reg_sel, reg_write, mem_read, done, err}, 0);
        @(negedge clk); reset = 0;
        @(posedge clk); #2;
        chk("rst_mem_after_reg_write", reg_write, 0);
        chk("rst_mem_after_busy", busy, 0);

        // lw with mem_ready never asserted
        @(negedge clk);
        instr_valid = 1; opcode = 6'h23; funct = 6'h00;
        acc = cyc; err_at = -1; saw_done = 0;
        for (int k = 0; k < 20; k++) begin
            @(posedge clk); #2;
            if (done) saw_done = 1;
            if (err && err_at < 0) err_at = cyc - acc;
            @(negedge clk); instr_valid = 0;
        end
        chk("no_ready_done", saw_done, 0);
`ifdef CTRL_WB_TIMEOUT_EN
        chk("timeout_err_cycle", err_at, 6);
        chk("timeout_busy_after", busy, 0);
`else
        chk("no_timeout_err", err_at, -1);
        chk("no_timeout_busy", busy, 1);
        chk("no_timeout_mem_read", mem_read, 1);
`endif
        reset = 1;
        @(negedge clk); reset = 0;
        repeat (2) @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/ctrl_writeback.md
CTRL_WRITEBACK -- requirements
Module: ctrl_writeback

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 16, meaning max cycles waited in MEM before abort (used only with macro).
REQ-002 SHALL have port clk  in  1  sole clock, all state on rising edge.
REQ-003 SHALL have port reset  in  1  synchronous, active-high reset.
REQ-004 SHALL have port instr_valid  in  1  instruction offer; accepted only in IDLE.
REQ-005 SHALL have port opcode  in  6  instruction bits [31:26], sampled on accept.
REQ-006 SHALL have port funct  in  6  instruction bits [5:0], sampled on accept.
REQ-007 SHALL have port mem_ready  in  1  memory read data valid.
REQ-008 SHALL have port reg_dst_sel  out  3  select to the RegDst mux.
REQ-009 SHALL have port mem_to_reg_sel  out  2  write-data source: 00 ALU, 01 memory, 10 PC+4, 11 LUI immediate.
REQ-010 SHALL have ports reg_write, mem_read, busy, done, err  out  1 each.

Function
REQ-011 SHALL implement states IDLE, DECODE, MEM, WB.
REQ-012 SHALL go IDLE->DECODE on instr_valid=1, latching opcode/funct; instr_valid outside IDLE ignored.
REQ-013 SHALL decode: opcode 0x00 (funct!=0x08) -> sel 001 (rd), src 00, write; opcode 0x00 funct 0x08 (jr) -> no write; 0x23 (lw) -> sel 000 (rt), src 01, write; 0x08/0x09/0x0A -> sel 000, src 00, write; 0x0F (lui) -> sel 000, src 11, write; 0x03 (jal) -> sel 010 ($31), src 10, write; any other opcode -> no write.
REQ-014 SHALL never drive reg_dst_sel values 011..111 (reserved).
REQ-015 SHALL go DECODE->MEM for lw, DECODE->WB otherwise.
REQ-016 SHALL assert mem_read=1 every MEM cycle; mem_ready=1 in MEM -> WB next cycle; minimum one MEM cycle; mem_ready outside MEM ignored.
REQ-017 SHALL in WB assert done=1 and reg_write=1 (writing instrs only) for exactly one cycle, then return to IDLE.
REQ-018 SHALL hold reg_dst_sel and mem_to_reg_sel stable from DECODE through WB; both 0 in IDLE.
REQ-019 SHALL assert busy=1 in every state except IDLE.
REQ-020 SHALL give latency accept->done of 2 cycles for non-load, 3+N cycles for lw (N = extra MEM wait cycles).
REQ-021 SHALL accept a new instr_valid in the IDLE cycle directly following WB (no back-to-back overlap).

Reset
REQ-022 SHALL on reset=1 at an edge enter IDLE with all outputs 0, counter cleared, regardless of state.
REQ-023 SHALL never assert reg_write in the cycle after a reset taken mid-operation.

Configuration
REQ-024 SHALL, with CTRL_WB_TIMEOUT_EN defined, count MEM cycles; TIMEOUT_CYCLES cycles without mem_ready -> IDLE, err=1 for one cycle, done=0, reg_write=0.
REQ-025 SHALL, without CTRL_WB_TIMEOUT_EN, wait in MEM indefinitely, tie err to 0 and omit the counter.
REQ-026 SHALL give mem_ready priority over timeout in the same cycle.

Structure
REQ-027 SHALL place opcode/funct constants, state encoding and reg_dst_sel/mem_to_reg_sel encodings in shared package ctrl_defs.
REQ-028 SHALL put the REQ-013 decode table in combinational sub-module decod_wb; FSM and counter stay in ctrl_writeback.

Verification
REQ-029 SHALL cover add (op 0x00, funct 0x20) -> done and reg_write at cycle +2, reg_dst_sel=001, src=00.
REQ-030 SHALL cover lw with mem_ready after 3 MEM cycles -> mem_read high 3 cycles, done at +5, sel=000, src=01.
REQ-031 SHALL cover jal (0x03) -> sel=010, src=10, reg_write one cycle; then jr -> done=1, reg_write=0.
REQ-032 SHALL cover reset asserted during MEM -> next cycle IDLE, all outputs 0, no reg_write.
REQ-033 SHALL cover, with macro, lw and mem_ready never high, TIMEOUT_CYCLES=4 -> err pulse after 4 MEM cycles, done=0; without macro busy stays 1.
REQ-034 SHALL cover instr_valid held high through DECODE/WB -> second instruction accepted only in IDLE after done.
